// File: rtl/cpu_pkg.sv
// Shared encodings and control-word types for the pipelined MIPS control unit.
package cpu_pkg;

    // Widths carried inside the stage control words.
    localparam int REG_W = 5;
    localparam int ALU_W = 4;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SHL   = 6'b000010;
    localparam logic [5:0] OP_SHR   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    // ALU control codes; shifts occupy 0100/0101 so they never alias add.
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_MULT = 4'b1000;

    // Full control word produced in ID and held in ID/EX.
    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch;
        logic             alu_src;
        logic [ALU_W-1:0] alu_control;
        logic [REG_W-1:0] wr_addr;
    } ctrl_t;

    // Later stages only keep the fields they still consume.
    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic [REG_W-1:0] wr_addr;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] wr_addr;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE = '0;
    localparam mem_ctrl_t MEM_BUBBLE  = '0;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main + ALU decoder: op/funct of the ID instruction to a control word.
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output ctrl_t            ctrl,
    output logic             illegal,
    output logic             reads_rt
);

    // Undecodable encodings fall back to a bubble so nothing downstream sees X.
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        illegal  = 1'b0;
        reads_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                reads_rt       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wr_addr   = rd;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    FN_MULT: ctrl.alu_control = ALU_MULT;
                    default: begin
                        ctrl     = CTRL_BUBBLE;
                        reads_rt = 1'b0;
                        illegal  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.wr_addr     = rt;
            end
            OP_SW: begin
                reads_rt         = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                reads_rt         = 1'b1;
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.wr_addr     = rt;
            end
            OP_SHL, OP_SHR: begin
                if (SHIFT_EN) begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_src     = 1'b1;
                    ctrl.alu_control = {2'b01, 1'b0, op[0]};
                    ctrl.wr_addr     = rt;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_NOP: ;
            default: illegal = 1'b1;
        endcase
        // $0 is hard-wired, so a write to it is dropped at the source.
        if (ctrl.wr_addr == '0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / branch hazard handling and multi-cycle MULT sequencing.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int MUL_LAT    = 4,
    parameter bit SHIFT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            id_op,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    output logic                  stall_if,
    output logic                  flush_id,
    output logic                  branch_taken,
    output logic                  ex_alu_src,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic                  ex_branch,
    output logic                  ex_mem_write,
    output logic                  mem_mem_write,
    output logic                  ex_reg_write,
    output logic                  mem_reg_write,
    output logic                  wb_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  mem_mem_to_reg,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] ex_wr_addr,
    output logic [REG_ADDR_W-1:0] mem_wr_addr,
    output logic [REG_ADDR_W-1:0] wb_wr_addr,
    output logic                  illegal_op
);

    // Counter only has to hold MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    ctrl_t      id_ctrl;
    logic       id_illegal;
    logic       id_reads_rt;
    ctrl_t      ex_q, ex_d;
    mem_ctrl_t  mem_q, mem_d;
    wb_ctrl_t   wb_q, wb_d;
    mul_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       busy;
    logic       load_use;

    ctrl_decode #(.SHIFT_EN(SHIFT_EN)) u_decode (
        .op       (id_op),
        .funct    (id_funct),
        .rt       (REG_W'(id_rt)),
        .rd       (REG_W'(id_rd)),
        .ctrl     (id_ctrl),
        .illegal  (id_illegal),
        .reads_rt (id_reads_rt)
    );

    // Hazard detection; a taken branch overrides every stall source.
    always_comb begin
        busy         = (state_q == MUL_BUSY);
        branch_taken = ex_q.branch & ex_zero;
        load_use     = ex_q.mem_to_reg && (ex_wr_addr != '0) && !busy &&
                       ((ex_wr_addr == id_rs) || ((ex_wr_addr == id_rt) && id_reads_rt));
        flush_id     = branch_taken;
        stall_if     = !branch_taken && (busy || load_use);
    end

    // Stage advance, bubble insertion and MULT sequencing.
    always_comb begin
        ex_d             = ex_q;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.wr_addr    = ex_q.wr_addr;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.mem_to_reg  = mem_q.mem_to_reg;
        wb_d.wr_addr     = mem_q.wr_addr;
        state_d          = state_q;
        cnt_d            = cnt_q;
        illegal_d        = 1'b0;
        if (busy) begin
            // MULT stays in EX; MEM sees bubbles until the counter runs out.
            mem_d = MEM_BUBBLE;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = MUL_IDLE;
            end
        end else if (branch_taken || load_use) begin
            ex_d = CTRL_BUBBLE;
        end else begin
            ex_d      = id_ctrl;
            illegal_d = id_illegal;
            // MULT entering EX: the cycle it arrives is the first busy cycle.
            if ((MUL_LAT > 1) && (id_ctrl.alu_control == ALU_MULT)) begin
                state_d = MUL_BUSY;
                cnt_d   = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    // Stage registers, FSM state and illegal pulse; reset clears all to bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= CTRL_BUBBLE;
            mem_q     <= MEM_BUBBLE;
            wb_q      <= '0;
            state_q   <= MUL_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_alu_src     = ex_q.alu_src;
    assign ex_alu_control = ALU_CTRL_W'(ex_q.alu_control);
    assign ex_branch      = ex_q.branch;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_to_reg  = ex_q.mem_to_reg;
    assign ex_wr_addr     = REG_ADDR_W'(ex_q.wr_addr);
    assign mem_mem_write  = mem_q.mem_write;
    assign mem_reg_write  = mem_q.reg_write;
    assign mem_mem_to_reg = mem_q.mem_to_reg;
    assign mem_wr_addr    = REG_ADDR_W'(mem_q.wr_addr);
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_mem_to_reg  = wb_q.mem_to_reg;
    assign wb_wr_addr     = REG_ADDR_W'(wb_q.wr_addr);
    assign illegal_op     = illegal_q;

endmodule
